// File: rtl/dpsk_diff_tx.sv
// DPSK link transmitter: one-byte holding buffer, '1'-bit preamble, then MSB-first data,
// every bit differentially encoded (d_k = b_k ^ d_(k-1)) and held for CLK_DIV cycles.
//
//   state | meaning
//   IDLE  | line holds its last level, waiting for a buffered byte
//   PRE   | sending PRE_BITS preamble '1' bits (toggle every bit)
//   DATA  | shifting out data bytes back-to-back while the buffer refills
module dpsk_diff_tx #(
    parameter int CLK_DIV  = 60,
    parameter int PRE_BITS = 32
) (
    input  logic       clk_12,
    input  logic       rst_i,
    input  logic [7:0] tx_data_i,
    input  logic       tx_valid_i,
    output logic       tx_ready_o,
    output logic       data_o,
    output logic       bit_clk_o,
    output logic       busy_o,
    output logic       done_o
);

    typedef enum logic [1:0] {IDLE, PRE, DATA} state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [7:0] DIV_HALF = 8'(CLK_DIV / 2);
    localparam logic [7:0] PRE_LAST = 8'(PRE_BITS - 1);

    state_t     state;
    logic [7:0] div_cnt;
    logic [7:0] pre_cnt;
    logic [2:0] bit_idx;
    logic [6:0] shreg;
    logic [7:0] buf_q;
    logic       buf_full;
    logic       boundary;
    logic       write_en;

    assign boundary = (state != IDLE) && (div_cnt == DIV_LAST);
    // A load needs buf_full=1, which holds tx_ready_o low, so a write never collides with it.
    assign write_en = tx_valid_i && tx_ready_o;

    always_ff @(posedge clk_12 or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            div_cnt    <= '0;
            pre_cnt    <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            buf_q      <= '0;
            buf_full   <= 1'b0;
            tx_ready_o <= 1'b1;
            data_o     <= 1'b0;
            bit_clk_o  <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
        end else begin
            done_o <= 1'b0;

            if (write_en) begin
                buf_q      <= tx_data_i;
                buf_full   <= 1'b1;
                tx_ready_o <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (buf_full) begin
                        state     <= PRE;
                        div_cnt   <= '0;
                        pre_cnt   <= '0;
                        data_o    <= ~data_o;
                        bit_clk_o <= 1'b1;
                        busy_o    <= 1'b1;
                    end
                end

                PRE, DATA: begin
                    if (!boundary) begin
                        div_cnt   <= div_cnt + 8'd1;
                        bit_clk_o <= (div_cnt + 8'd1) < DIV_HALF;
                    end else begin
                        div_cnt   <= '0;
                        bit_clk_o <= 1'b1;
                        if (state == PRE) begin
                            pre_cnt <= pre_cnt + 8'd1;
                            if (pre_cnt == PRE_LAST) begin
                                shreg      <= buf_q[6:0];
                                buf_full   <= 1'b0;
                                tx_ready_o <= 1'b1;
                                bit_idx    <= 3'd7;
                                state      <= DATA;
                                data_o     <= data_o ^ buf_q[7];
                            end else begin
                                data_o <= ~data_o;
                            end
                        end else if (bit_idx != 3'd0) begin
                            bit_idx <= bit_idx - 3'd1;
                            data_o  <= data_o ^ shreg[bit_idx - 3'd1];
                        end else if (buf_full) begin
                            // Next byte follows with no gap and no new preamble.
                            shreg      <= buf_q[6:0];
                            buf_full   <= 1'b0;
                            tx_ready_o <= 1'b1;
                            bit_idx    <= 3'd7;
                            data_o     <= data_o ^ buf_q[7];
                        end else begin
                            state     <= IDLE;
                            done_o    <= 1'b1;
                            busy_o    <= 1'b0;
                            bit_clk_o <= 1'b0;
                        end
                    end
                end

                default: begin
                    state     <= IDLE;
                    div_cnt   <= '0;
                    busy_o    <= 1'b0;
                    bit_clk_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dpsk_diff_tx.sv
// Bench for dpsk_diff_tx: fixed level vectors, hand-written corner sequences and random
// traffic; a stream monitor decodes every frame and compares it with the bytes sent.
module tb_dpsk_diff_tx;

    localparam int CLK_DIV  = 4;
    localparam int PRE_BITS = 4;
    localparam int NB       = PRE_BITS + 8;
    localparam int FRAME1   = NB * CLK_DIV;
    localparam int LIMIT    = 2000;

    logic       clk_12 = 1'b0;
    logic       rst    = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       data_o;
    logic       bit_clk;
    logic       busy;
    logic       done;

    always #5 clk_12 = ~clk_12;

    dpsk_diff_tx #(.CLK_DIV(CLK_DIV), .PRE_BITS(PRE_BITS)) dut (
        .clk_12    (clk_12),
        .rst_i     (rst),
        .tx_data_i (tx_data),
        .tx_valid_i(tx_valid),
        .tx_ready_o(tx_ready),
        .data_o    (data_o),
        .bit_clk_o (bit_clk),
        .busy_o    (busy),
        .done_o    (done)
    );

    int checks   = 0;
    int errors   = 0;
    int done_cnt = 0;
    logic [7:0] sent_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_12);
        #1;
    endtask

    // ---------------- stream monitor / reference decoder ----------------
    logic mon_in   = 1'b0;
    logic idle_lvl = 1'b0;
    logic lvl_q[$];
    logic bc_q[$];

    task automatic check_frame();
        int   n;
        int   nb;
        logic prev;
        logic b;
        logic [7:0] byt;
        logic ok_shape, ok_flat, ok_bc, ok_pre;
        n  = lvl_q.size();
        nb = n / CLK_DIV;
        ok_shape = (n % CLK_DIV == 0) && (nb > PRE_BITS) && ((nb - PRE_BITS) % 8 == 0);
        chk("frame_len", ok_shape, 1);
        if (ok_shape) begin
            ok_flat = 1'b1;
            ok_bc   = 1'b1;
            ok_pre  = 1'b1;
            byt     = 8'h00;
            prev    = idle_lvl;
            for (int c = 0; c < n; c++) begin
                if (lvl_q[c] !== lvl_q[(c / CLK_DIV) * CLK_DIV]) ok_flat = 1'b0;
                if (bc_q[c] !== ((c % CLK_DIV) < CLK_DIV / 2)) ok_bc = 1'b0;
            end
            chk("bit_level_steady", ok_flat, 1);
            chk("bit_clk_shape", ok_bc, 1);
            for (int k = 0; k < nb; k++) begin
                b    = lvl_q[k * CLK_DIV] ^ prev;
                prev = lvl_q[k * CLK_DIV];
                if (k < PRE_BITS) begin
                    if (!b) ok_pre = 1'b0;
                end else begin
                    byt = {byt[6:0], b};
                    if ((k - PRE_BITS) % 8 == 7) begin
                        if (sent_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL rx_extra: got byte %0h expected none", byt);
                        end else begin
                            chk("rx_byte", byt, sent_q.pop_front());
                        end
                    end
                end
            end
            chk("preamble_ones", ok_pre, 1);
        end
    endtask

    always @(posedge clk_12) begin
        #1;
        if (rst) begin
            mon_in = 1'b0;
            lvl_q.delete();
            bc_q.delete();
            idle_lvl = data_o;
        end else begin
            if (done) done_cnt++;
            if (busy) begin
                lvl_q.push_back(data_o);
                bc_q.push_back(bit_clk);
                mon_in = 1'b1;
            end else begin
                if (mon_in) begin
                    check_frame();
                    chk("done_at_end", done, 1);
                    mon_in = 1'b0;
                    lvl_q.delete();
                    bc_q.delete();
                end else if (bit_clk !== 1'b0) begin
                    chk("bit_clk_idle", bit_clk, 0);
                end
                idle_lvl = data_o;
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic push(input logic [7:0] b);
        logic acc;
        acc      = 1'b0;
        tx_data  = b;
        tx_valid = 1'b1;
        for (int i = 0; i < LIMIT && !acc; i++) begin
            acc = tx_ready;
            tick();
        end
        tx_valid = 1'b0;
        chk("accept", acc, 1);
        if (acc) begin
            sent_q.push_back(b);
            chk("ready_low_when_full", tx_ready, 0);
        end
    endtask

    task automatic wait_busy();
        int i;
        i = 0;
        while (!busy && i < LIMIT) begin
            tick();
            i++;
        end
        chk("busy_start", busy, 1);
    endtask

    task automatic wait_idle();
        int i;
        i = 0;
        while (!(!busy && tx_ready) && i < LIMIT) begin
            tick();
            i++;
        end
        chk("idle_reached", !busy && tx_ready, 1);
        tick();
    endtask

    typedef struct {
        logic [7:0]    data;
        logic [NB-1:0] lv;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   d0;
        logic ok_l, ok_b;

        // first-bit-first levels: 4 preamble bits then 8 data bits
        vecs[0] = '{8'hA5, 12'b1010_1100_0110};
        vecs[1] = '{8'h00, 12'b1010_0000_0000};
        vecs[2] = '{8'hFF, 12'b1010_1010_1010};
        vecs[3] = '{8'h80, 12'b1010_1111_1111};
        vecs[4] = '{8'h3C, 12'b0101_1101_0111};
        vecs[5] = '{8'h01, 12'b0101_1111_1110};

        rst = 1'b1;
        repeat (3) tick();
        chk("rst_data", data_o, 0);
        chk("rst_bit_clk", bit_clk, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ready", tx_ready, 1);
        rst = 1'b0;
        tick();

        for (int v = 0; v < 6; v++) begin
            push(vecs[v].data);
            wait_busy();
            for (int k = 0; k < NB; k++) begin
                ok_l = 1'b1;
                ok_b = 1'b1;
                for (int c = 0; c < CLK_DIV; c++) begin
                    if (data_o !== vecs[v].lv[NB-1-k]) ok_l = 1'b0;
                    if (bit_clk !== (c < CLK_DIV / 2)) ok_b = 1'b0;
                    tick();
                end
                chk($sformatf("vec%0d_bit%0d_level", v, k), ok_l, 1);
                chk($sformatf("vec%0d_bit%0d_bitclk", v, k), ok_b, 1);
            end
            chk($sformatf("vec%0d_done", v), done, 1);
            chk($sformatf("vec%0d_busy_fall", v), busy, 0);
            chk($sformatf("vec%0d_hold", v), data_o, vecs[v].lv[0]);
            tick();
            chk($sformatf("vec%0d_done_pulse", v), done, 0);
        end

        // back-to-back 0x00 then 0xFF, second written during data bit 3
        d0 = done_cnt;
        push(8'h00);
        wait_busy();
        repeat ((PRE_BITS + 3) * CLK_DIV) tick();
        push(8'hFF);
        wait_idle();
        chk("b2b_one_done", done_cnt - d0, 1);

        // valid held high over three bytes
        d0 = done_cnt;
        push(8'h12);
        push(8'h34);
        push(8'h56);
        wait_idle();
        chk("burst_one_done", done_cnt - d0, 1);

        // async reset in data bit 4 of 0x3C with a second byte buffered
        push(8'h3C);
        wait_busy();
        repeat ((PRE_BITS + 1) * CLK_DIV) tick();
        push(8'hC3);
        repeat (3 * CLK_DIV) tick();
        chk("pre_rst_busy", busy, 1);
        chk("pre_rst_ready", tx_ready, 0);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_busy", busy, 0);
        chk("async_rst_data", data_o, 0);
        chk("async_rst_bit_clk", bit_clk, 0);
        chk("async_rst_ready", tx_ready, 1);
        chk("async_rst_done", done, 0);
        tick();
        #3 rst = 1'b0;
        sent_q.delete();
        tick();
        chk("post_rst_idle", busy, 0);
        push(8'h5A);
        wait_idle();

        // byte written exactly on the final-bit boundary edge
        push(8'h96);
        wait_busy();
        repeat (FRAME1 - 1) tick();
        push(8'h69);
        wait_idle();

        for (int it = 0; it < 40; it++) begin
            int nbytes;
            nbytes = $urandom_range(1, 3);
            for (int b = 0; b < nbytes; b++) begin
                push(8'($urandom_range(0, 255)));
                repeat ($urandom_range(0, 60)) tick();
            end
            wait_idle();
        end

        repeat (5) tick();
        chk("all_bytes_received", sent_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
